acc_proc_core: RTL

Parametrised multicycle accumulator processor core for the image-processing datapath. It is the next-generation replacement for the fixed 8/16-bit fetch/execute system. Width, address space and GP register count are parametrised. The internal RAM is replaced by a req/ack data-memory handshake, and the core adds register-indirect load (pixel-pointer walking), Z-conditional branches and HALT. Instruction memory is external, asynchronous-read ROM.

---
 rtl/acc_proc_pkg.sv | 45 ++++
 rtl/acc_proc_if.sv | 41 ++++
 rtl/acc_proc_alu.sv | 42 ++++
 rtl/acc_proc_core.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/acc_proc_pkg.sv
// Shared definitions for the accumulator processor core: opcodes, FSM state
// encoding and instruction field positions.
package acc_proc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_MVR   = 4'h3;
    localparam logic [3:0] OP_MVAC  = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_INC   = 4'h9;
    localparam logic [3:0] OP_LDI   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JPZ   = 4'hC;
    localparam logic [3:0] OP_JPNZ  = 4'hD;
    localparam logic [3:0] OP_LDIND = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int K_MSB   = 7;
    localparam int K_LSB   = 0;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDAC) || (op == OP_STAC) || (op == OP_LDIND);
    endfunction

    // Opcodes MVAC..LDI all write AC from the ALU result during EXEC.
    function automatic logic writes_ac_exec(input logic [3:0] op);
        return (op >= OP_MVAC) && (op <= OP_LDI);
    endfunction

endpackage

// File: rtl/acc_proc_if.sv
// Instruction-fetch and data-memory bus between the core (master) and the
// memory subsystem (slave).
interface acc_proc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    // imem_data is combinational from imem_addr. dmem_req rises with
    // addr/we/wdata and holds them stable until the single-cycle dmem_ack;
    // the transfer completes on the clock edge where req and ack are both
    // high. An ack while req is low carries no meaning.
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_addr,
        input  imem_data,
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/acc_proc_alu.sv
// Combinational ALU for the accumulator core. Defining ACC_PROC_PIXEL_SAT_EN
// makes ADD/INC saturate high and SUB clamp at zero instead of wrapping.
module acc_proc_alu
    import acc_proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

`ifdef ACC_PROC_PIXEL_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [DATA_W:0] incr;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        incr   = {1'b0, a} + (DATA_W+1)'(1);
        result = b;
        case (op)
            OP_ADD: result = (SAT && sum[DATA_W])  ? '1 : sum[DATA_W-1:0];
            OP_SUB: result = (SAT && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_INC: result = (SAT && incr[DATA_W]) ? '1 : incr[DATA_W-1:0];
            // MVAC, LDI and the loads simply pass the selected B operand
            default: result = b;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_proc_core.sv
// Multicycle accumulator processor: FETCH/EXEC/MEM/HALT sequencer, GP file and
// req/ack data-memory port. Optional build macro: ACC_PROC_PIXEL_SAT_EN.
module acc_proc_core
    import acc_proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_GP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    acc_proc_if.master        bus,
    output logic              halted,
    output logic              z_flag,
    output state_t            state_dbg,
    output logic [DATA_W-1:0] ac_dbg
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] ac;
    logic              z;
    logic [DATA_W-1:0] gp [NUM_GP];
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic [3:0]        op;
    logic [3:0]        rn;
    logic [7:0]        k;
    logic [DATA_W-1:0] gp_rd;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;
    logic              jump_taken;

    assign op = ir[OPC_MSB:OPC_LSB];
    assign rn = ir[REG_MSB:REG_LSB];
    assign k  = ir[K_MSB:K_LSB];

    // Indices beyond the implemented GP file read as zero.
    always_comb begin
        gp_rd = '0;
        for (int i = 0; i < NUM_GP; i++) begin
            if (rn == 4'(i)) gp_rd = gp[i];
        end
    end

    always_comb begin
        alu_b = gp_rd;
        if (state == ST_MEM)   alu_b = bus.dmem_rdata;
        else if (op == OP_LDI) alu_b = DATA_W'(k);
    end

    assign jump_taken = (op == OP_JMP) || ((op == OP_JPZ) && z) ||
                        ((op == OP_JPNZ) && !z);

    acc_proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (ac),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_HALT)     state_nxt = ST_HALT;
                else if (is_mem_op(op)) state_nxt = ST_MEM;
                else                   state_nxt = ST_FETCH;
            end
            ST_MEM:   if (bus.dmem_ack) state_nxt = ST_FETCH;
            default:  state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        halted         = (state == ST_HALT);
        state_dbg      = state;
        ac_dbg         = ac;
        z_flag         = z;
        bus.imem_addr  = pc;
        bus.dmem_req   = req;
        bus.dmem_we    = we;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            ir    <= '0;
            ac    <= '0;
            z     <= 1'b0;
            req   <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            for (int i = 0; i < NUM_GP; i++) gp[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir <= bus.imem_data;
                    pc <= pc + ADDR_W'(1);
                end
                ST_EXEC: begin
                    if (writes_ac_exec(op)) begin
                        ac <= alu_res;
                        z  <= alu_zero;
                    end
                    if (op == OP_MVR) begin
                        for (int i = 0; i < NUM_GP; i++) begin
                            if (rn == 4'(i)) gp[i] <= ac;
                        end
                    end
                    if (jump_taken) pc <= k[ADDR_W-1:0];
                    if (is_mem_op(op)) begin
                        req   <= 1'b1;
                        we    <= (op == OP_STAC);
                        addr  <= (op == OP_LDIND) ? gp_rd[ADDR_W-1:0] : k[ADDR_W-1:0];
                        wdata <= ac;
                    end
                end
                ST_MEM: begin
                    // Request stays frozen until the ack cycle.
                    if (bus.dmem_ack) begin
                        req <= 1'b0;
                        if (op != OP_STAC) begin
                            ac <= alu_res;
                            z  <= alu_zero;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
